// File: rtl/pll_sup_pkg.sv
// pll_sup_pkg: shared state encoding and widths for the PLL lock supervisor
package pll_sup_pkg;

    typedef enum logic [2:0] {
        PLL_RESET,
        WAIT_LOCK,
        STABILIZE,
        RELEASE,
        RUN
    } state_t;

    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 65536;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_RELEASE_GAP    = 8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m > d ? m : d;
    endfunction

    localparam int CNT_W   = $clog2(max4(DEF_PLL_RST_CYCLES, DEF_LOCK_TIMEOUT,
                                         DEF_STABLE_CYCLES, DEF_RELEASE_GAP));
    localparam int COUNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit, reset to 0
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: PLL reset sequencing, lock qualification and staged reset release
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int RELEASE_GAP    = DEF_RELEASE_GAP
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               pll_locked,
    input  logic               force_reset,
    output logic               pll_rst,
    output logic [1:0]         rst_out,
    output logic               ready,
    output logic [COUNT_W-1:0] retry_count,
    output logic [COUNT_W-1:0] lock_loss_count
);

    state_t           st, nxt;
    logic [CNT_W-1:0] cnt;
    logic             lock_s, inc_retry, inc_loss;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            st  <= PLL_RESET;
            cnt <= '0;
        end else begin
            st  <= nxt;
            cnt <= (nxt != st || force_reset) ? '0 : cnt + 1'b1;
        end
    end

    // lock drop outranks a coinciding count expiry; force_reset outranks everything
    always_comb begin
        nxt       = st;
        inc_retry = 1'b0;
        inc_loss  = 1'b0;
        if (force_reset)
            nxt = PLL_RESET;
        else
            case (st)
                PLL_RESET: nxt = (cnt == CNT_W'(PLL_RST_CYCLES - 1)) ? WAIT_LOCK : PLL_RESET;
                WAIT_LOCK: begin
                    if (lock_s)
                        nxt = STABILIZE;
                    else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        nxt       = PLL_RESET;
                        inc_retry = 1'b1;
                    end
                end
                STABILIZE: nxt = !lock_s ? WAIT_LOCK :
                                 (cnt == CNT_W'(STABLE_CYCLES - 1)) ? RELEASE : STABILIZE;
                RELEASE: begin
                    inc_loss = !lock_s;
                    nxt      = !lock_s ? PLL_RESET :
                               (cnt == CNT_W'(RELEASE_GAP - 1)) ? RUN : RELEASE;
                end
                RUN: begin
                    inc_loss = !lock_s;
                    nxt      = !lock_s ? PLL_RESET : RUN;
                end
                default: nxt = PLL_RESET;
            endcase
    end

    always_comb begin
        pll_rst = st == PLL_RESET;
        rst_out = (st == RUN) ? 2'b00 : (st == RELEASE) ? 2'b10 : 2'b11;
        ready   = st == RUN;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            retry_count     <= '0;
            lock_loss_count <= '0;
        end else begin
            if (inc_retry && retry_count != '1)
                retry_count <= retry_count + 1'b1;
            if (inc_loss && lock_loss_count != '1)
                lock_loss_count <= lock_loss_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: randomized and directed checks against a cycle-level behavioural model
module tb_pll_lock_supervisor;

    localparam int PRC = 4;
    localparam int TO  = 20;
    localparam int STB = 8;
    localparam int GAP = 3;

    localparam int M_PR = 0, M_WL = 1, M_ST = 2, M_REL = 3, M_RUN = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1, pll_locked = 1'b0, force_reset = 1'b0;
    logic       pll_rst, ready;
    logic [1:0] rst_out;
    logic [7:0] retry_count, lock_loss_count;

    int vectors = 0, miscompares = 0;

    int   m_ph, m_age, m_retry, m_loss;
    logic m_hist[2];

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (PRC),
        .LOCK_TIMEOUT   (TO),
        .STABLE_CYCLES  (STB),
        .RELEASE_GAP    (GAP)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .force_reset     (force_reset),
        .pll_rst         (pll_rst),
        .rst_out         (rst_out),
        .ready           (ready),
        .retry_count     (retry_count),
        .lock_loss_count (lock_loss_count)
    );

    always #10 refclk = ~refclk;

    task automatic model_reset();
        m_ph = M_PR; m_age = 0; m_retry = 0; m_loss = 0;
        m_hist[0] = 1'b0; m_hist[1] = 1'b0;
    endtask

    // one clock of the supervisor's rules, applied to the inputs seen at that edge
    task automatic model_step(input logic r, input logic lk, input logic f);
        int   nph;
        logic ls;
        if (r) begin
            model_reset();
            return;
        end
        ls  = m_hist[1];
        nph = m_ph;
        if (f) nph = M_PR;
        else if (m_ph == M_PR && m_age == PRC - 1) nph = M_WL;
        else if (m_ph == M_WL && ls) nph = M_ST;
        else if (m_ph == M_WL && m_age == TO - 1) begin
            nph = M_PR;
            m_retry = m_retry < 255 ? m_retry + 1 : 255;
        end
        else if (m_ph == M_ST && !ls) nph = M_WL;
        else if (m_ph == M_ST && m_age == STB - 1) nph = M_REL;
        else if ((m_ph == M_REL || m_ph == M_RUN) && !ls) begin
            nph = M_PR;
            m_loss = m_loss < 255 ? m_loss + 1 : 255;
        end
        else if (m_ph == M_REL && m_age == GAP - 1) nph = M_RUN;
        m_age     = (f || nph != m_ph) ? 0 : m_age + 1;
        m_ph      = nph;
        m_hist[1] = m_hist[0];
        m_hist[0] = lk;
    endtask

    task automatic check();
        logic       e_rst, e_rdy;
        logic [1:0] e_out;
        e_rst = m_ph == M_PR;
        e_rdy = m_ph == M_RUN;
        e_out = m_ph == M_RUN ? 2'b00 : m_ph == M_REL ? 2'b10 : 2'b11;
        vectors++;
        if (pll_rst !== e_rst || rst_out !== e_out || ready !== e_rdy ||
            retry_count !== 8'(m_retry) || lock_loss_count !== 8'(m_loss)) begin
            miscompares++;
            $display("FAIL cycle_cmp t=%0t got pll_rst=%b rst_out=%b ready=%b retry=%0d loss=%0d want %b %b %b %0d %0d",
                     $time, pll_rst, rst_out, ready, retry_count, lock_loss_count,
                     e_rst, e_out, e_rdy, m_retry, m_loss);
        end
    endtask

    task automatic pin(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic lk, input logic f);
        check();
        rst = r; pll_locked = lk; force_reset = f;
        @(posedge refclk);
        model_step(r, lk, f);
        @(negedge refclk);
    endtask

    task automatic do_rst();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic lk;
        @(posedge refclk);
        model_reset();
        @(negedge refclk);
        do_rst();
        pin("reset_pll_rst", pll_rst, 1);
        pin("reset_rst_out", rst_out, 3);
        pin("reset_ready", ready, 0);

        // clean lock
        for (int c = 0; c < 40; c++) begin
            if (c == 3)  pin("clean_pll_rst_c3", pll_rst, 1);
            if (c == 4)  pin("clean_pll_rst_c4", pll_rst, 0);
            if (c == 20) pin("clean_rst_out_c20", rst_out, 3);
            if (c == 21) pin("clean_rst_out_c21", rst_out, 2);
            if (c == 23) pin("clean_ready_c23", ready, 0);
            if (c == 24) pin("clean_rst_out_c24", rst_out, 0);
            if (c == 24) pin("clean_ready_c24", ready, 1);
            if (c == 39) pin("clean_counts", retry_count + lock_loss_count, 0);
            step(1'b0, c >= 10, 1'b0);
        end

        // one-cycle glitch during STABILIZE
        do_rst();
        for (int c = 0; c < 40; c++) begin
            if (c == 26) pin("glitch_rst_out_c26", rst_out, 3);
            if (c == 27) pin("glitch_rst_out_c27", rst_out, 2);
            if (c == 29) pin("glitch_ready_c29", ready, 0);
            if (c == 30) pin("glitch_ready_c30", ready, 1);
            if (c == 39) pin("glitch_counts", retry_count + lock_loss_count, 0);
            step(1'b0, c >= 10 && c != 15, 1'b0);
        end

        // lock loss in RUN, then relock
        do_rst();
        for (int c = 0; c < 70; c++) begin
            if (c == 42) pin("loss_ready_c42", ready, 1);
            if (c == 43) pin("loss_pll_rst_c43", pll_rst, 1);
            if (c == 43) pin("loss_rst_out_c43", rst_out, 3);
            if (c == 43) pin("loss_ready_c43", ready, 0);
            if (c == 43) pin("loss_count_c43", lock_loss_count, 1);
            if (c == 64) pin("loss_relock_ready_c64", ready, 1);
            step(1'b0, (c >= 10 && c < 40) || c >= 50, 1'b0);
        end

        // force_reset coinciding with lock_s falling in RUN
        do_rst();
        for (int c = 0; c < 40; c++) begin
            if (c == 33) pin("prio_pll_rst_c33", pll_rst, 1);
            if (c == 33) pin("prio_loss_c33", lock_loss_count, 0);
            step(1'b0, c >= 10 && c < 30, c == 32);
        end

        // no lock: periodic retries
        do_rst();
        for (int c = 0; c < 80; c++) begin
            if (c == 23) pin("nolock_retry_c23", retry_count, 0);
            if (c == 23) pin("nolock_pll_rst_c23", pll_rst, 0);
            if (c == 24) pin("nolock_retry_c24", retry_count, 1);
            if (c == 27) pin("nolock_pll_rst_c27", pll_rst, 1);
            if (c == 28) pin("nolock_pll_rst_c28", pll_rst, 0);
            if (c == 48) pin("nolock_retry_c48", retry_count, 2);
            if (c == 72) pin("nolock_retry_c72", retry_count, 3);
            step(1'b0, 1'b0, 1'b0);
        end

        // saturation over 300 timeouts, then reset mid-PLL_RESET
        do_rst();
        for (int c = 0; c < 7202; c++) step(1'b0, 1'b0, 1'b0);
        pin("sat_retry", retry_count, 255);
        pin("sat_in_pll_reset", pll_rst, 1);
        step(1'b1, 1'b0, 1'b0);
        pin("sat_rst_retry", retry_count, 0);
        pin("sat_rst_rst_out", rst_out, 3);
        for (int c = 0; c < 10; c++) step(1'b0, 1'b0, 1'b0);

        // randomized lock behaviour with occasional force_reset and rst
        lk = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 39) == 0) lk = ~lk;
            step($urandom_range(0, 799) == 0, lk, $urandom_range(0, 59) == 0);
        end
        check();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
